seg7_scan_capture: RTL and testbench

SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_to_hex.sv | 26 ++
 rtl/seg7_scan_capture.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Holds the common-anode segment patterns (active-low, bit0=a .. bit6=g),
// the capture FSM state codes and a hex-to-segment encoder built from the
// same patterns, so the encode and decode directions share one table.
package seg7_pkg;

  localparam logic [6:0] Seg0 = 7'b1000000;
  localparam logic [6:0] Seg1 = 7'b1111001;
  localparam logic [6:0] Seg2 = 7'b0100100;
  localparam logic [6:0] Seg3 = 7'b0110000;
  localparam logic [6:0] Seg4 = 7'b0011001;
  localparam logic [6:0] Seg5 = 7'b0010010;
  localparam logic [6:0] Seg6 = 7'b0000010;
  localparam logic [6:0] Seg7 = 7'b1111000;
  localparam logic [6:0] Seg8 = 7'b0000000;
  localparam logic [6:0] Seg9 = 7'b0010000;
  localparam logic [6:0] SegA = 7'b0001000;
  localparam logic [6:0] SegB = 7'b0000011;
  localparam logic [6:0] SegC = 7'b1000110;
  localparam logic [6:0] SegD = 7'b0100001;
  localparam logic [6:0] SegE = 7'b0000110;
  localparam logic [6:0] SegF = 7'b0001110;

  // Capture FSM state codes
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StTrack = 2'd1;
  localparam logic [1:0] StHeld  = 2'd2;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = Seg0;
      4'h1:    seg = Seg1;
      4'h2:    seg = Seg2;
      4'h3:    seg = Seg3;
      4'h4:    seg = Seg4;
      4'h5:    seg = Seg5;
      4'h6:    seg = Seg6;
      4'h7:    seg = Seg7;
      4'h8:    seg = Seg8;
      4'h9:    seg = Seg9;
      4'hA:    seg = SegA;
      4'hB:    seg = SegB;
      4'hC:    seg = SegC;
      4'hD:    seg = SegD;
      4'hE:    seg = SegE;
      default: seg = SegF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the common-anode segment table.
// Ports:
//   seg_n  in   7  active-low segment pattern (bit0=a .. bit6=g)
//   value  out  4  recovered hex digit (0 when the pattern is illegal)
//   legal  out  1  pattern matches one of the 16 table entries
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       legal
);

  // Table entries are unique, so at most one iteration matches.
  always_comb begin
    value = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == hex_to_seg(4'(i))) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the hex digits shown on a multiplexed common-anode 7-segment
// display by snooping its segment and digit-select lines.
// A digit is captured once the same (segment, select) sample has been seen
// for STABLE_CYCLES consecutive synchronized cycles; it is not re-captured
// until the sample changes.
// Ports:
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   seg_n        in   7         segment lines, active-low, bit0=a .. bit6=g
//   dig_sel_n    in   DIGITS    digit anode enables, active-low
//   hex_out      out  4*DIGITS  captured hex value, nibble i = digit i
//   digit_valid  out  DIGITS    digit i holds a legal captured value
//   digit_err    out  DIGITS    last capture on digit i was illegal
//   update       out  1         one-cycle pulse per capture
//   update_idx   out  IdxW      digit captured, valid while update=1
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_sel_n,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  update,
  output logic [IdxW-1:0]       update_idx
);

  localparam logic [CntW-1:0] Thresh = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Two-flop synchronizers; all-ones means nothing lit.
  logic [6:0]        seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0] sel_s1_q, sel_s2_q;

  // Previous synchronized sample, for stability comparison
  logic [6:0]        prev_seg_q;
  logic [DIGITS-1:0] prev_sel_q;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            capture;

  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                update_q;
  logic [IdxW-1:0]     update_idx_q, update_idx_d;

  logic            selected;
  logic            same;
  logic [IdxW-1:0] sel_idx;
  logic [3:0]      dec_value;
  logic            dec_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      sel_s1_q   <= '1;
      sel_s2_q   <= '1;
      prev_seg_q <= '1;
      prev_sel_q <= '1;
    end else begin
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      sel_s1_q   <= dig_sel_n;
      sel_s2_q   <= sel_s1_q;
      prev_seg_q <= seg_s2_q;
      prev_sel_q <= sel_s2_q;
    end
  end

  always_comb begin
    selected = $onehot(~sel_s2_q);
    same     = (seg_s2_q == prev_seg_q) && (sel_s2_q == prev_sel_q);
    sel_idx  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!sel_s2_q[i]) sel_idx = IdxW'(i);
    end
  end

  seg7_to_hex u_seg7_to_hex (
    .seg_n (seg_s2_q),
    .value (dec_value),
    .legal (dec_legal)
  );

  // In TRACK the counter is always below Thresh, so the increment never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (selected) begin
          state_d = StTrack;
          cnt_d   = CntOne;
        end
      end
      StTrack: begin
        if (!selected) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = cnt_q + CntOne;
          if (cnt_d == Thresh) begin
            capture = 1'b1;
            state_d = StHeld;
          end
        end else begin
          cnt_d = CntOne;
        end
      end
      StHeld: begin
        if (!selected) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = StTrack;
          cnt_d   = CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture only happens on a selected sample, so exactly one select bit is low.
  always_comb begin
    hex_d        = hex_q;
    valid_d      = valid_q;
    err_d        = err_q;
    update_idx_d = capture ? sel_idx : update_idx_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (capture && !sel_s2_q[i]) begin
        if (dec_legal) begin
          hex_d[4*i +: 4] = dec_value;
          valid_d[i]      = 1'b1;
          err_d[i]        = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q        <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
    end else begin
      hex_q        <= hex_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      update_q     <= capture;
      update_idx_q <= update_idx_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign update      = update_q;
  assign update_idx  = update_idx_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture (DIGITS=4, STABLE_CYCLES=4).
// Reference model: pins reach the decision logic two cycles late; a capture
// happens when the run of identical selected samples reaches exactly
// STABLE_CYCLES, and shows on the outputs one cycle later.
module tb_seg7_scan_capture;

  localparam int Stable = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel_n;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        update;
  logic [1:0]  update_idx;

  seg7_scan_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (Stable)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel_n   (dig_sel_n),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .update      (update),
    .update_idx  (update_idx)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_checks = 0;
  int n_pass   = 0;
  int upd_seen = 0;

  // Reference model state
  logic [10:0] mq [$];
  logic [10:0] m_last;
  int          run;
  logic [15:0] m_hex;
  logic [3:0]  m_valid, m_err;
  logic        m_update;
  int          m_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    mq = {};
    mq.push_back(11'h7FF);
    mq.push_back(11'h7FF);
    m_last   = 11'h7FF;
    run      = 0;
    m_hex    = '0;
    m_valid  = '0;
    m_err    = '0;
    m_update = 1'b0;
    m_idx    = 0;
  endtask

  task automatic model_step(input logic [10:0] pin);
    logic [10:0] samp;
    logic [3:0]  sel;
    int          zeros, idx, val;
    bit          found;
    mq.push_back(pin);
    samp  = mq.pop_front();
    sel   = samp[10:7];
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < 4; i++) begin
      if (!sel[i]) begin
        zeros++;
        idx = i;
      end
    end
    m_update = 1'b0;
    if (zeros == 1) run = (run > 0 && samp == m_last) ? run + 1 : 1;
    else run = 0;
    m_last = samp;
    if (run == Stable) begin
      found = 1'b0;
      val   = 0;
      for (int k = 0; k < 16; k++) begin
        if (tbl[k] == samp[6:0]) begin
          found = 1'b1;
          val   = k;
        end
      end
      if (found) begin
        m_hex[4*idx +: 4] = val[3:0];
        m_valid[idx]      = 1'b1;
        m_err[idx]        = 1'b0;
      end else begin
        m_valid[idx] = 1'b0;
        m_err[idx]   = 1'b1;
      end
      m_update = 1'b1;
      m_idx    = idx;
    end
  endtask

  // Called at a falling edge; drives pins, advances one clock, compares.
  task automatic cycle(input logic [6:0] s, input logic [3:0] d);
    seg_n     = s;
    dig_sel_n = d;
    model_step({d, s});
    @(posedge clk);
    @(negedge clk);
    if (update) upd_seen++;
    check_eq("update", update, m_update);
    if (m_update) check_eq("update_idx", update_idx, m_idx);
    check_eq("hex_out", hex_out, m_hex);
    check_eq("digit_valid", digit_valid, m_valid);
    check_eq("digit_err", digit_err, m_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_hex", hex_out, 0);
    check_eq("rst_valid", digit_valid, 0);
    check_eq("rst_err", digit_err, 0);
    check_eq("rst_update", update, 0);
    check_eq("rst_idx", update_idx, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] s;
    logic [3:0] d;
    int         hold;
    seg_n     = 7'h7F;
    dig_sel_n = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_hex", hex_out, 0);
    check_eq("reset_valid", digit_valid, 0);
    check_eq("reset_err", digit_err, 0);
    check_eq("reset_update", update, 0);
    rst_n = 1'b1;

    // Steady digit 3 on position 0: capture after six cycles
    repeat (6) cycle(7'b0110000, 4'b1110);
    check_eq("d030_update", update, 1);
    check_eq("d030_idx", update_idx, 0);
    check_eq("d030_hex0", hex_out[3:0], 4'h3);
    check_eq("d030_valid", digit_valid, 4'b0001);

    // Illegal blank pattern: flags error, keeps old nibble
    repeat (8) cycle(7'b1111111, 4'b1110);
    check_eq("d032_err0", digit_err[0], 1);
    check_eq("d032_valid0", digit_valid[0], 0);
    check_eq("d032_hex0", hex_out[3:0], 4'h3);

    // Three-digit scan from reset
    do_reset();
    upd_seen = 0;
    repeat (8) cycle(7'b0010010, 4'b1101);
    repeat (8) cycle(7'b0001000, 4'b1011);
    repeat (8) cycle(7'b0100001, 4'b0111);
    check_eq("d031_hex", hex_out, 16'hDA50);
    check_eq("d031_valid", digit_valid, 4'b1110);
    check_eq("d031_pulses", upd_seen, 3);

    // No digit or several digits selected: never captures
    upd_seen = 0;
    repeat (20) cycle(7'b0000000, 4'b1100);
    repeat (20) cycle(7'b0000000, 4'b1111);
    check_eq("d033_pulses", upd_seen, 0);

    // Change one sample short of the threshold: no capture, count restarts
    upd_seen = 0;
    repeat (3) cycle(7'b1111001, 4'b1110);
    repeat (3) cycle(7'b0011001, 4'b1110);
    check_eq("d034_no_cap", upd_seen, 0);
    repeat (3) cycle(7'b0011001, 4'b1110);
    check_eq("d034_restart", upd_seen, 1);

    // Reset mid-count, then a full latency is needed again
    repeat (4) cycle(7'b0000010, 4'b1011);
    do_reset();
    upd_seen = 0;
    repeat (5) cycle(7'b0000010, 4'b1011);
    check_eq("d034_no_early", upd_seen, 0);
    cycle(7'b0000010, 4'b1011);
    check_eq("d034_capture", update, 1);
    check_eq("d034_hex2", hex_out[11:8], 4'h6);

    // Randomized scan traffic against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 99) < 3) do_reset();
      if ($urandom_range(0, 99) < 85) s = tbl[$urandom_range(0, 15)];
      else s = 7'($urandom);
      if ($urandom_range(0, 99) < 80) d = ~(4'b0001 << $urandom_range(0, 3));
      else d = 4'($urandom);
      hold = $urandom_range(1, 9);
      repeat (hold) cycle(s, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
